ball_motion: RTL

- Generates the ball position (x_loc, y_loc) consumed by the downstream blob-drawing stage of the laser projector pipeline.
- Updates position once per video frame, at the first vertical-blank line, so the drawn blob never tears mid-frame.
- Applies launch velocity, gravity, wall reflections and a paddle-bounce request.
- Reports a drain when the ball leaves the bottom of the playfield.

---
 rtl/ball_motion_pkg.sv | 10 +
 rtl/ball_motion_frame_tick_gen.sv | 16 +
 rtl/ball_motion.sv | 103 ++++++++++
 3 files changed

// File: rtl/ball_motion_pkg.sv
// ball_motion_pkg: playfield geometry, FSM encoding and velocity width shared by the ball and drawing stages.
package ball_motion_pkg;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BLOB_SIZE = 8;
  localparam int VEL_W     = 5;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
endpackage

// File: rtl/ball_motion_frame_tick_gen.sv
// frame_tick_gen: one registered pulse per frame, the cycle after the first vertical-blank line starts.
module frame_tick_gen
  import ball_motion_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  output logic       tick
);
  logic tick_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) tick_q <= 1'b0;
    else       tick_q <= (hcount == 10'd0) && (vcount == 10'(SCREEN_H));
  assign tick = tick_q;
endmodule

// File: rtl/ball_motion.sv
// ball_motion: per-frame ball position with launch, gravity, wall reflection, paddle bounce and drain detection.
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter int X_INIT   = 316,
  parameter int Y_INIT   = 400,
  parameter int GRAV_DIV = 4,
  parameter int MAX_VY   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [9:0]       hcount,
  input  logic [9:0]       vcount,
  input  logic             enable,
  input  logic             launch,
  input  logic [VEL_W-1:0] vx_in,
  input  logic [VEL_W-1:0] vy_in,
  input  logic             bounce_up,
  output logic [9:0]       x_loc,
  output logic [9:0]       y_loc,
  output logic             ball_active,
  output logic             drain
);
  localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - BLOB_SIZE);
  localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H - BLOB_SIZE);
  localparam logic signed [11:0] VY_MAX = 12'(MAX_VY);
  logic                    tick;
  logic [1:0]              state_q, state_d;
  logic [9:0]              x_q, x_d, y_q, y_d;
  logic signed [VEL_W-1:0] vx_q, vx_d, vy_q, vy_d;
  logic [7:0]              gc_q, gc_d;
  logic                    latch_q, latch_d, active_q, drain_q;
  logic                    upd, grav;
  logic signed [11:0]      nx, ny, vyp, vyb;
  frame_tick_gen u_tick (
    .clk    (clk),
    .reset  (reset),
    .hcount (hcount),
    .vcount (vcount),
    .tick   (tick)
  );
  assign upd  = tick && enable && (state_q == ST_RUN);
  assign grav = gc_q == 8'(GRAV_DIV - 1);
  assign nx   = signed'({2'b00, x_q}) + 12'(vx_q);
  assign ny   = signed'({2'b00, y_q}) + 12'(vy_q);
  assign vyp  = ny < 0 ? -12'(vy_q) : 12'(vy_q);
  assign vyb  = (latch_q && vyp > 0) ? -vyp : vyp;
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    gc_d    = gc_q;
    latch_d = bounce_up | (latch_q & ~upd);
    if (state_q == ST_IDLE && launch) begin
      state_d = ST_RUN;
      vx_d    = vx_in;
      vy_d    = vy_in;
      gc_d    = '0;
    end else if (upd && ny > Y_MAX) begin
      state_d = ST_DRAIN;
    end else if (upd) begin
      x_d  = nx < 0 ? 10'd0 : nx > X_MAX ? 10'(X_MAX) : 10'(nx);
      vx_d = (nx < 0 || nx > X_MAX) ? -vx_q : vx_q;
      y_d  = ny < 0 ? 10'd0 : 10'(ny);
      vy_d = VEL_W'(grav ? (vyb >= VY_MAX ? VY_MAX : vyb + 12'sd1) : vyb);
      gc_d = grav ? 8'd0 : gc_q + 8'd1;
    end else if (state_q == ST_DRAIN) begin
      state_d = ST_IDLE;
      x_d     = 10'(X_INIT);
      y_d     = 10'(Y_INIT);
      vx_d    = '0;
      vy_d    = '0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= ST_IDLE;
      x_q      <= 10'(X_INIT);
      y_q      <= 10'(Y_INIT);
      vx_q     <= '0;
      vy_q     <= '0;
      gc_q     <= '0;
      latch_q  <= 1'b0;
      active_q <= 1'b0;
      drain_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vx_q     <= vx_d;
      vy_q     <= vy_d;
      gc_q     <= gc_d;
      latch_q  <= latch_d;
      active_q <= state_d == ST_RUN;
      drain_q  <= state_d == ST_DRAIN;
    end
  assign x_loc       = x_q;
  assign y_loc       = y_q;
  assign ball_active = active_q;
  assign drain       = drain_q;
endmodule
